// File: rtl/netlist_bist_ctrl.sv
// ============================================================================
// netlist_bist_ctrl
// ----------------------------------------------------------------------------
// Built-in self-test sequencer for the single-output combinational benchmark
// netlists (34 inputs, 1 output). A 34-bit LFSR supplies pseudo-random input
// patterns. Each pattern is held for SETTLE+1 cycles. The netlist output is
// sampled in the last cycle of each pattern and folded into a CRC-16
// signature (poly 0x1021). At the end of the run the signature is compared
// against a golden value.
//
// Parameters:
//   IN_W    width of the netlist input vector (LFSR taps are fixed for 34)
//   CNT_W   width of the pattern counter and num_pat
//   SETTLE  cycles each pattern settles before the capture cycle (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       run request, only looked at while idle
//   seed        LFSR seed, latched on an accepted start (0 is mapped to 1)
//   num_pat     number of patterns to apply, latched on an accepted start
//   golden_sig  expected signature, latched on an accepted start
//   dut_out     netlist output bit
//   dut_in      netlist input vector (zero whenever not busy)
//   busy        high while patterns are being applied
//   done        one-cycle completion pulse
//   pass        signature matched golden_sig; valid from done until next start
//   signature   running / final signature
//
// Optional feature (compile-time macro NETLIST_BIST_ABORT_EN):
//   abort       input, cancels a run that is in APPLY or CAPTURE
//   aborted     output, set by a cancelled run, cleared on the next start
// ============================================================================
module netlist_bist_ctrl #(
  parameter int IN_W   = 34,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  seed,
  input  logic [CNT_W-1:0] num_pat,
  input  logic [15:0]      golden_sig,
  input  logic             dut_out,
  output logic [IN_W-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
`ifdef NETLIST_BIST_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CAPTURE,
    DONE
  } state_t;

  // The settle counter only has to reach SETTLE-1; keep it at least one bit.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);
  localparam logic [15:0]      SIG_INIT    = 16'hFFFF;
  localparam logic [15:0]      CRC_POLY    = 16'h1021;
  localparam logic [IN_W-1:0]  SEED_GUARD  = IN_W'(1);

  state_t           state;
  state_t           state_next;
  logic [IN_W-1:0]  lfsr;
  logic [IN_W-1:0]  lfsr_next;
  logic             lfsr_fb;
  logic [15:0]      sig;
  logic [15:0]      sig_next;
  logic [CNT_W-1:0] pat_cnt;
  logic [CNT_W:0]   pat_cnt_inc;
  logic [CNT_W-1:0] num_pat_q;
  logic [15:0]      golden_q;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_last;
  logic             last_pat;
  logic             pass_q;
  logic             abort_req;
  logic             abort_hit;
  logic             run_active;

`ifdef NETLIST_BIST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Pattern generator: taps 33, 26, 1, 0 give a maximal-length 34-bit
  // sequence, so any nonzero seed never reaches the all-zero lock-up state.
  assign lfsr_fb   = lfsr[33] ^ lfsr[26] ^ lfsr[1] ^ lfsr[0];
  assign lfsr_next = {lfsr[IN_W-2:0], lfsr_fb};

  // CRC-16 compression of the single sampled output bit.
  assign sig_next = {sig[14:0], 1'b0} ^ ((sig[15] ^ dut_out) ? CRC_POLY : 16'h0000);

  // The counter is widened by one bit for the compare so that a full-scale
  // num_pat can never be matched by a wrapped count.
  assign pat_cnt_inc = {1'b0, pat_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last_pat    = (pat_cnt_inc == {1'b0, num_pat_q});
  assign settle_last = (settle_cnt == SETTLE_LAST);

  assign run_active = (state == APPLY) || (state == CAPTURE);
  assign abort_hit  = abort_req && run_active;

  // State register of the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode. The netlist only ever sees the LFSR while a
  // pattern is being applied or captured; otherwise it is held at zero.
  always_comb begin
    state_next = state;
    dut_in     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_pat == '0) ? DONE : APPLY;
        end
      end
      APPLY: begin
        dut_in = lfsr;
        busy   = 1'b1;
        if (abort_req) begin
          state_next = IDLE;
        end else if (settle_last) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        dut_in = lfsr;
        busy   = 1'b1;
        if (abort_req) begin
          state_next = IDLE;
        end else if (last_pat) begin
          state_next = DONE;
        end else begin
          state_next = APPLY;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Run datapath: latches the run parameters on an accepted start, counts
  // settle cycles, and on each capture folds dut_out into the signature and
  // steps the LFSR. pass is resolved on the edge that enters DONE so it is
  // already valid while done is high, and then holds until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= '0;
      sig        <= SIG_INIT;
      pat_cnt    <= '0;
      num_pat_q  <= '0;
      golden_q   <= '0;
      settle_cnt <= '0;
      pass_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr       <= (seed == '0) ? SEED_GUARD : seed;
            sig        <= SIG_INIT;
            pat_cnt    <= '0;
            num_pat_q  <= num_pat;
            golden_q   <= golden_sig;
            settle_cnt <= '0;
            pass_q     <= (num_pat == '0) && (golden_sig == SIG_INIT);
          end
        end
        APPLY: begin
          if (abort_req) begin
            pass_q     <= 1'b0;
            settle_cnt <= '0;
          end else if (settle_last) begin
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_ONE;
          end
        end
        CAPTURE: begin
          settle_cnt <= '0;
          if (abort_req) begin
            pass_q <= 1'b0;
          end else begin
            sig     <= sig_next;
            lfsr    <= lfsr_next;
            pat_cnt <= pat_cnt_inc[CNT_W-1:0];
            if (last_pat) begin
              pass_q <= (sig_next == golden_q);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef NETLIST_BIST_ABORT_EN
  // Sticky abort flag: set by a cancelled run, cleared when a new run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted <= 1'b0;
    end else if ((state == IDLE) && start) begin
      aborted <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end
  end
`endif

  assign signature = sig;
  assign pass      = pass_q;

endmodule

// File: tb/tb_netlist_bist_ctrl.sv
// ============================================================================
// tb_netlist_bist_ctrl
// ----------------------------------------------------------------------------
// Bench for netlist_bist_ctrl. A run-level model tracks where each run is by
// cycle index since the accepting edge: pattern p occupies cycles
// p*(SETTLE+1)+1 .. (p+1)*(SETTLE+1), done is cycle num_pat*(SETTLE+1)+1.
// Every cycle the DUT outputs are compared against that model, and a few
// directed runs additionally pin hand-computed literal values.
// ============================================================================
module tb_netlist_bist_ctrl;

  localparam int S = 2;
  localparam int P = S + 1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [33:0] seed;
  logic [15:0] num_pat;
  logic [15:0] golden_sig;
  logic        dut_out;
  logic [33:0] dut_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
`ifdef NETLIST_BIST_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  int vectors;
  int miscompares;

  // Run-level reference model state
  bit          m_run;
  int          m_k;
  int          m_n;
  logic [33:0] m_pat;
  logic [15:0] m_sig;
  logic [15:0] m_gold;
  bit          m_pass;
  bit          m_aborted;

  int dout_mode;
  bit pbits[$];

  netlist_bist_ctrl #(
    .IN_W   (34),
    .CNT_W  (16),
    .SETTLE (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .num_pat    (num_pat),
    .golden_sig (golden_sig),
    .dut_out    (dut_out),
    .dut_in     (dut_in),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
`ifdef NETLIST_BIST_ABORT_EN
    ,
    .abort      (abort),
    .aborted    (aborted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] lfsrStep(input logic [33:0] x);
    logic [33:0] tapMask;
    tapMask = 34'h0;
    tapMask[33] = 1'b1;
    tapMask[26] = 1'b1;
    tapMask[1]  = 1'b1;
    tapMask[0]  = 1'b1;
    return {x[32:0], ^(x & tapMask)};
  endfunction

  function automatic logic [15:0] crcStep(input logic [15:0] s, input bit b);
    logic [15:0] r;
    r = s << 1;
    if ((s[15] ^ b) == 1'b1) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_run     = 0;
    m_k       = 0;
    m_n       = 0;
    m_pat     = '0;
    m_sig     = 16'hFFFF;
    m_gold    = '0;
    m_pass    = 0;
    m_aborted = 0;
  endtask

  function automatic bit expBusy();
    return m_run && (m_k >= 1) && (m_k <= m_n * P);
  endfunction

  function automatic bit expDone();
    return m_run && (m_k == m_n * P + 1);
  endfunction

  // Compare every observable output against the model for the current cycle.
  task automatic checkOutput();
    logic [33:0] expIn;
    expIn = expBusy() ? m_pat : 34'h0;
    checkVal("dut_in",    64'(dut_in),    64'(expIn));
    checkVal("busy",      64'(busy),      64'(expBusy()));
    checkVal("done",      64'(done),      64'(expDone()));
    checkVal("pass",      64'(pass),      64'(m_pass));
    checkVal("signature", 64'(signature), 64'(m_sig));
`ifdef NETLIST_BIST_ABORT_EN
    checkVal("aborted",   64'(aborted),   64'(m_aborted));
`endif
  endtask

  // Advance the model across the coming clock edge using the inputs that are
  // currently being driven.
  task automatic modelAdvance();
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (m_run) begin
`ifdef NETLIST_BIST_ABORT_EN
      if (abort && expBusy()) begin
        m_run     = 0;
        m_pass    = 0;
        m_aborted = 1;
        return;
      end
`endif
      if (expBusy() && (m_k % P == 0)) begin
        m_sig = crcStep(m_sig, dut_out);
        m_pat = lfsrStep(m_pat);
        if (m_k == m_n * P) m_pass = (m_sig == m_gold);
        m_k++;
      end else if (expDone()) begin
        m_run = 0;
      end else begin
        m_k++;
      end
    end else if (start) begin
      m_run     = 1;
      m_k       = 1;
      m_n       = int'(num_pat);
      m_gold    = golden_sig;
      m_pat     = (seed == 34'h0) ? 34'h1 : seed;
      m_sig     = 16'hFFFF;
      m_pass    = (num_pat == 16'h0) && (golden_sig == 16'hFFFF);
      m_aborted = 0;
    end
  endtask

  // Drive dut_out for the current cycle, step the model, then observe the DUT
  // one time unit after the next rising edge.
  task automatic applyStimulus();
    if (dout_mode == 0) begin
      dut_out = 1'b0;
    end else if (dout_mode == 2 && expBusy()) begin
      dut_out = pbits[(m_k - 1) / P];
    end else begin
      dut_out = 1'($urandom_range(0, 1));
    end
    modelAdvance();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runStart(input logic [33:0] s, input int n, input logic [15:0] g);
    seed       = s;
    num_pat    = 16'(n);
    golden_sig = g;
    start      = 1'b1;
    applyStimulus();
    start      = 1'b0;
  endtask

  initial begin
    logic [63:0] rnd;
    logic [15:0] good;
    int          n;
    int          len;

    vectors     = 0;
    miscompares = 0;
    dout_mode   = 1;
    rst_n       = 1'b0;
    start       = 1'b0;
    seed        = '0;
    num_pat     = '0;
    golden_sig  = '0;
    dut_out     = 1'b0;
`ifdef NETLIST_BIST_ABORT_EN
    abort       = 1'b0;
`endif
    modelReset();

    // Reset values, checked while held and after release.
    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput();
    checkVal("reset_sig_literal", 64'(signature), 64'h0000_0000_0000_FFFF);
    repeat (2) applyStimulus();

    // Zero-pattern run: done right after the accepting edge, busy never high.
    $display("[TB] zero-pattern run");
    runStart(34'h5, 0, 16'hFFFF);
    checkVal("zero_done_lit", 64'(done), 64'h1);
    checkVal("zero_pass_lit", 64'(pass), 64'h1);
    checkVal("zero_busy_lit", 64'(busy), 64'h0);
    applyStimulus();
    checkVal("zero_done_drop", 64'(done), 64'h0);

    // Three-pattern run with dut_out tied low and a restart attempt mid-run.
    $display("[TB] three-pattern run");
    dout_mode = 0;
    runStart(34'h1, 3, 16'h8F1F);
    for (int k = 1; k <= 11; k++) begin
      logic [33:0] litIn;
      litIn = (k <= 3) ? 34'h1 : (k <= 6) ? 34'h3 : (k <= 9) ? 34'h6 : 34'h0;
      checkVal($sformatf("tri_in_k%0d", k),   64'(dut_in), 64'(litIn));
      checkVal($sformatf("tri_busy_k%0d", k), 64'(busy),   64'(k <= 9));
      checkVal($sformatf("tri_done_k%0d", k), 64'(done),   64'(k == 10));
      if (k >= 10) begin
        checkVal($sformatf("tri_sig_k%0d", k),  64'(signature), 64'h8F1F);
        checkVal($sformatf("tri_pass_k%0d", k), 64'(pass),       64'h1);
      end
      if (k == 4) begin
        start   = 1'b1;
        seed    = 34'h2_DEAD_BEEF;
        num_pat = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (k < 11) applyStimulus();
    end

    // Seed guard and failing signature.
    $display("[TB] seed guard / fail path");
    dout_mode = 1;
    runStart(34'h0, 1, 16'h0000);
    checkVal("guard_in_lit", 64'(dut_in), 64'h1);
    for (int k = 2; k <= 5; k++) begin
      applyStimulus();
      if (k == 4) begin
        checkVal("guard_done_lit", 64'(done), 64'h1);
        checkVal("guard_pass_lit", 64'(pass), 64'h0);
      end
    end

    // Asynchronous reset in the middle of a run: no done afterwards.
    $display("[TB] reset mid-run");
    dout_mode = 0;
    runStart(34'h1, 3, 16'h8F1F);
    repeat (4) applyStimulus();
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkVal("rst_busy_lit", 64'(busy), 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12) applyStimulus();

`ifdef NETLIST_BIST_ABORT_EN
    // Abort in the middle of a run, then confirm aborted clears on restart.
    $display("[TB] abort mid-run");
    runStart(34'h1, 3, 16'h8F1F);
    repeat (4) applyStimulus();
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkVal("abort_flag_lit", 64'(aborted), 64'h1);
    checkVal("abort_busy_lit", 64'(busy),    64'h0);
    checkVal("abort_in_lit",   64'(dut_in),  64'h0);
    repeat (12) applyStimulus();
    runStart(34'h7, 1, 16'h1234);
    repeat (5) applyStimulus();
`endif

    // Randomized runs with ignored restarts and per-pattern output bits.
    $display("[TB] randomized runs");
    dout_mode = 2;
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(0, 3)) applyStimulus();
      n = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(0, 9));
      len = n * P;
      pbits.delete();
      good = 16'hFFFF;
      for (int p = 0; p < n; p++) begin
        bit b;
        b = 1'($urandom_range(0, 1));
        pbits.push_back(b);
        good = crcStep(good, b);
      end
      rnd = {$urandom, $urandom};
      runStart(($urandom_range(0, 7) == 0) ? 34'h0 : rnd[33:0], n,
               ($urandom_range(0, 1) == 1) ? good : 16'($urandom));
      for (int k = 1; k <= len + 1; k++) begin
        if (k <= len && $urandom_range(0, 6) == 0) begin
          start   = 1'b1;
          rnd     = {$urandom, $urandom};
          seed    = rnd[33:0];
          num_pat = 16'($urandom_range(1, 50));
        end else begin
          start = 1'b0;
        end
        applyStimulus();
      end
      start = 1'b0;
    end
    repeat (3) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
